// File: rtl/mac_sched_pkg.sv
// Shared types and default widths for the MAC job scheduler.
package mac_sched_pkg;

   localparam int DATA_W = 8;
   localparam int ACC_W  = 16;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      STREAM,
      DRAIN,
      RESULT
   } state_t;

endpackage

// File: rtl/mac_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr, wrapping.
module mac_rr_arbiter
   import mac_sched_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         grant,
   output logic [$clog2(NREQ)-1:0] grant_idx,
   output logic                    found
);

   localparam int ID_W = $clog2(NREQ);

   int slot;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      slot      = 0;
      for (int k = 0; k < NREQ; k++) begin
         slot = (int'(ptr) + k) % NREQ;
         if (!found && req[slot]) begin
            found       = 1'b1;
            grant[slot] = 1'b1;
            grant_idx   = ID_W'(slot);
         end
      end
   end

endmodule

// File: rtl/mac_job_scheduler.sv
// Round-robin scheduler sharing one MAC between NREQ dot-product clients.
// Optional operand-starvation abort is enabled by defining MAC_SCHED_TIMEOUT_EN.
module mac_job_scheduler
   import mac_sched_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int LEN_W   = 4,
   parameter int DATA_W  = mac_sched_pkg::DATA_W,
   parameter int ACC_W   = mac_sched_pkg::ACC_W,
   parameter int TIMEOUT = 15
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*LEN_W-1:0]   req_len,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ-1:0]         op_valid,
   input  logic [NREQ*DATA_W-1:0]  op_a,
   input  logic [NREQ*DATA_W-1:0]  op_b,
   output logic [NREQ-1:0]         op_ready,
   output logic                    mac_clr,
   output logic                    mac_en,
   output logic [DATA_W-1:0]       mac_a,
   output logic [DATA_W-1:0]       mac_b,
   input  logic [ACC_W-1:0]        mac_acc,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [ACC_W-1:0]        res_data,
   output logic [$clog2(NREQ)-1:0] res_id,
   output logic                    res_err,
   output logic                    busy
);

   localparam int ID_W = $clog2(NREQ);

   state_t            state;
   state_t            state_nxt;
   logic [NREQ-1:0]   grant;
   logic [ID_W-1:0]   grant_idx;
   logic              grant_any;
   logic [ID_W-1:0]   owner;
   logic [ID_W-1:0]   rr_ptr;
   logic [LEN_W-1:0]  len_sel;
   logic [LEN_W-1:0]  cnt;
   logic              accept;
   logic              last_accept;
   logic              timeout_hit;

   mac_rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .found     (grant_any)
   );

   assign len_sel     = req_len[int'(grant_idx)*LEN_W +: LEN_W];
   assign accept      = (state == STREAM) && op_valid[owner];
   assign last_accept = accept && (cnt == LEN_W'(1));
   assign res_id      = owner;

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      op_ready  = '0;
      mac_clr   = 1'b0;
      mac_en    = 1'b0;
      mac_a     = '0;
      mac_b     = '0;
      res_valid = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (grant_any) begin
               req_ready = grant;
               state_nxt = (len_sel == '0) ? RESULT : CLEAR;
            end
         end
         CLEAR: begin
            mac_clr   = 1'b1;
            state_nxt = STREAM;
         end
         STREAM: begin
            // Operands go straight through so the MAC sees them in the accept cycle.
            op_ready[owner] = 1'b1;
            mac_a  = op_a[int'(owner)*DATA_W +: DATA_W];
            mac_b  = op_b[int'(owner)*DATA_W +: DATA_W];
            mac_en = accept;
            if (last_accept || timeout_hit) state_nxt = DRAIN;
         end
         DRAIN: begin
            state_nxt = RESULT;
         end
         RESULT: begin
            res_valid = 1'b1;
            if (res_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         owner    <= '0;
         cnt      <= '0;
         res_data <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (grant_any) begin
                  owner    <= grant_idx;
                  cnt      <= len_sel;
                  res_data <= '0;
                  rr_ptr   <= (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);
               end
            end
            STREAM: begin
               if (accept) cnt <= cnt - LEN_W'(1);
            end
            // The MAC registered the last product on the edge entering this state.
            DRAIN: res_data <= mac_acc;
            default: ;
         endcase
      end
   end

`ifdef MAC_SCHED_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT + 1);

   logic [IDLE_W-1:0] idle_cnt;
   logic              err_q;

   assign timeout_hit = (state == STREAM) && !accept && (idle_cnt == IDLE_W'(TIMEOUT - 1));
   assign res_err     = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            IDLE:   if (grant_any) err_q <= 1'b0;
            CLEAR:  idle_cnt <= '0;
            STREAM: begin
               if (accept) idle_cnt <= '0;
               else        idle_cnt <= idle_cnt + IDLE_W'(1);
               if (timeout_hit) err_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign res_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mac_job_scheduler.sv
// Directed and randomized bench for mac_job_scheduler with a behavioural MAC and dot-product model.
module tb_mac_job_scheduler;

   localparam int NREQ   = 2;
   localparam int LEN_W  = 4;
   localparam int DATA_W = 8;
   localparam int ACC_W  = 16;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ*LEN_W-1:0]  req_len;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ-1:0]        op_valid;
   logic [NREQ*DATA_W-1:0] op_a;
   logic [NREQ*DATA_W-1:0] op_b;
   logic [NREQ-1:0]        op_ready;
   logic                   mac_clr;
   logic                   mac_en;
   logic [DATA_W-1:0]      mac_a;
   logic [DATA_W-1:0]      mac_b;
   logic [ACC_W-1:0]       mac_acc;
   logic                   res_valid;
   logic                   res_ready;
   logic [ACC_W-1:0]       res_data;
   logic [0:0]             res_id;
   logic                   res_err;
   logic                   busy;

   int n_cmp = 0;
   int n_bad = 0;
   int ptr_m = 0;
   logic [7:0] pa [16];
   logic [7:0] pb [16];

   int   clr_total = 0;
   int   en_total  = 0;
   int   order_err = 0;
   logic armed     = 1'b0;

   mac_job_scheduler #(.NREQ(NREQ), .LEN_W(LEN_W), .DATA_W(DATA_W), .ACC_W(ACC_W), .TIMEOUT(15)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_len   (req_len),
      .req_ready (req_ready),
      .op_valid  (op_valid),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_ready  (op_ready),
      .mac_clr   (mac_clr),
      .mac_en    (mac_en),
      .mac_a     (mac_a),
      .mac_b     (mac_b),
      .mac_acc   (mac_acc),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_id    (res_id),
      .res_err   (res_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Behavioural MAC: registered accumulator, wraps at 16 bits.
   always @(posedge clk) begin
      if (mac_clr)     mac_acc <= '0;
      else if (mac_en) mac_acc <= mac_acc + 16'(mac_a) * 16'(mac_b);
   end

   always @(posedge clk) begin
      if (rst) armed <= 1'b0;
      else begin
         if (mac_clr) begin
            clr_total <= clr_total + 1;
            armed     <= 1'b1;
         end
         if (mac_en) begin
            en_total <= en_total + 1;
            if (!armed) order_err <= order_err + 1;
         end
         if (res_valid) armed <= 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] m, input int p);
      for (int k = 0; k < NREQ; k++)
         if (m[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   // Runs one job for requester id using pa/pb[0..len-1]; caller is at negedge+1.
   task automatic do_job(input int id, input int len, input bit gaps, input bit noise, input int hold);
      int t;
      int k;
      int c0;
      int e0;
      int o0;
      int exp_g;
      logic [15:0] expv;
      expv = '0;
      for (int i = 0; i < len; i++) expv = expv + 16'(pa[i]) * 16'(pb[i]);
      c0 = clr_total;
      e0 = en_total;
      o0 = order_err;
      req_len[id*LEN_W +: LEN_W] = LEN_W'(len);
      req_valid[id] = 1'b1;
      #1;
      t = 0;
      while (req_ready == '0 && t < 50) begin
         @(negedge clk); #1; t++;
      end
      exp_g = pick(req_valid, ptr_m);
      chk("grant", 64'(req_ready), 64'(1 << exp_g));
      ptr_m = (exp_g + 1) % NREQ;
      t = 0;
      k = 0;
      while (k < len && t < 300) begin
         @(negedge clk); #1; t++;
         req_valid[id] = 1'b0;
         if (gaps && $urandom_range(0, 2) == 0) begin
            op_valid[id] = 1'b0;
            op_a[id*DATA_W +: DATA_W] = 8'($urandom);
            op_b[id*DATA_W +: DATA_W] = 8'($urandom);
         end else begin
            op_valid[id] = 1'b1;
            op_a[id*DATA_W +: DATA_W] = pa[k];
            op_b[id*DATA_W +: DATA_W] = pb[k];
         end
         if (noise)
            for (int j = 0; j < NREQ; j++)
               if (j != id) begin
                  op_valid[j] = 1'($urandom_range(0, 1));
                  op_a[j*DATA_W +: DATA_W] = 8'($urandom);
                  op_b[j*DATA_W +: DATA_W] = 8'($urandom);
               end
         #1;
         chk("op_ready_owner_only", 64'(op_ready & ~NREQ'(1 << id)), 64'(0));
         if (op_valid[id] && op_ready[id]) k++;
      end
      do begin
         @(negedge clk); #1; t++;
         op_valid = '0;
         req_valid[id] = 1'b0;
      end while (!res_valid && t < 300);
      chk("res_valid", 64'(res_valid), 64'(1));
      if (!gaps) chk("latency", 64'(t), 64'((len == 0) ? 1 : len + 3));
      chk("res_data", 64'(res_data), 64'(expv));
      chk("res_id", 64'(res_id), 64'(id));
      chk("res_err", 64'(res_err), 64'(0));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk); #1;
         chk("hold_valid", 64'(res_valid), 64'(1));
         chk("hold_data", 64'(res_data), 64'(expv));
         chk("hold_no_grant", 64'(req_ready), 64'(0));
      end
      res_ready = 1'b1;
      @(negedge clk); #1;
      res_ready = 1'b0;
      chk("res_valid_drop", 64'(res_valid), 64'(0));
      chk("clr_count", 64'(clr_total - c0), 64'((len > 0) ? 1 : 0));
      chk("en_count", 64'(en_total - e0), 64'(len));
      chk("clr_before_en", 64'(order_err - o0), 64'(0));
   endtask

   initial begin
      int t;
      int ln;
      rst = 1'b1;
      req_valid = '0;
      req_len = '0;
      op_valid = '0;
      op_a = '0;
      op_b = '0;
      res_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_outputs", 64'({req_ready, op_ready, mac_clr, mac_en, mac_a, mac_b,
                                res_valid, res_data, res_id, res_err, busy}), 64'(0));
      rst = 1'b0;
      @(negedge clk); #1;

      // Simultaneous requests: req0 then req1, then req0 wins again.
      req_len = {4'd1, 4'd1};
      req_valid = 2'b11;
      pa[0] = 8'd1; pb[0] = 8'd1;
      do_job(0, 1, 1'b0, 1'b0, 0);
      pa[0] = 8'd2; pb[0] = 8'd2;
      do_job(1, 1, 1'b0, 1'b0, 0);
      req_len = {4'd0, 4'd1};
      req_valid = 2'b11;
      pa[0] = 8'd7; pb[0] = 8'd9;
      do_job(0, 1, 1'b0, 1'b0, 0);
      do_job(1, 0, 1'b0, 1'b0, 0);

      pa[0] = 8'd3;  pb[0] = 8'd4;
      pa[1] = 8'd2;  pb[1] = 8'd5;
      pa[2] = 8'd10; pb[2] = 8'd10;
      do_job(0, 3, 1'b0, 1'b0, 0);

      // Wrap with req0 pending during the held result.
      req_len[0 +: LEN_W] = 4'd0;
      req_valid[0] = 1'b1;
      pa[0] = 8'd255; pb[0] = 8'd255;
      pa[1] = 8'd255; pb[1] = 8'd255;
      do_job(1, 2, 1'b0, 1'b0, 5);
      do_job(0, 0, 1'b0, 1'b0, 0);

      for (int i = 0; i < 5; i++) begin
         pa[i] = 8'($urandom);
         pb[i] = 8'($urandom);
      end
      do_job(1, 5, 1'b1, 1'b1, 1);

      // Reset in the middle of STREAM.
      pa[0] = 8'd2; pb[0] = 8'd3;
      req_len[0 +: LEN_W] = 4'd3;
      req_valid[0] = 1'b1;
      t = 0;
      #1;
      while (req_ready == '0 && t < 50) begin
         @(negedge clk); #1; t++;
      end
      chk("grant_before_reset", 64'(req_ready), 64'(1));
      repeat (3) begin
         @(negedge clk); #1;
         req_valid = '0;
         op_valid[0] = 1'b1;
         op_a[0 +: DATA_W] = pa[0];
         op_b[0 +: DATA_W] = pb[0];
      end
      @(negedge clk); #1;
      op_valid = '0;
      rst = 1'b1;
      @(negedge clk); #1;
      chk("midjob_reset_outputs", 64'({req_ready, op_ready, mac_clr, mac_en, mac_a, mac_b,
                                       res_valid, res_data, res_id, res_err, busy}), 64'(0));
      rst = 1'b0;
      ptr_m = 0;
      t = 0;
      repeat (20) begin
         @(negedge clk); #1;
         if (res_valid || busy) t++;
      end
      chk("no_result_after_reset", 64'(t), 64'(0));

`ifdef MAC_SCHED_TIMEOUT_EN
      req_len[0 +: LEN_W] = 4'd3;
      req_valid[0] = 1'b1;
      t = 0;
      #1;
      while (req_ready == '0 && t < 50) begin
         @(negedge clk); #1; t++;
      end
      chk("timeout_grant", 64'(req_ready), 64'(1));
      ptr_m = 1;
      t = 0;
      @(negedge clk); #1; t++;
      req_valid = '0;
      op_valid[0] = 1'b1;
      op_a[0 +: DATA_W] = 8'd2;
      op_b[0 +: DATA_W] = 8'd3;
      @(negedge clk); #1; t++;
      do begin
         @(negedge clk); #1; t++;
         op_valid = '0;
      end while (!res_valid && t < 100);
      chk("timeout_latency", 64'(t), 64'(19));
      chk("timeout_err", 64'(res_err), 64'(1));
      chk("timeout_data", 64'(res_data), 64'(16'h0006));
      res_ready = 1'b1;
      @(negedge clk); #1;
      res_ready = 1'b0;
`endif

      for (int n = 0; n < 12; n++) begin
         ln = $urandom_range(0, 6);
         for (int i = 0; i < ln; i++) begin
            pa[i] = 8'($urandom);
            pb[i] = 8'($urandom);
         end
         do_job($urandom_range(0, NREQ - 1), ln, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
